trivium_ctrl: RTL

TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

---
 rtl/trivium_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/trivium_ctrl.sv
// trivium_ctrl: sequencer for a bit-serial Trivium keystream core.
// After a start request it loads key/IV, runs the warm-up rounds, then assembles keystream
// bits into bytes (first bit in bit 0). Each byte is presented with a valid/ready handshake,
// and the core is frozen while a byte waits to be accepted. The session ends after MAX_BYTES
// bytes.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-low reset
//   start     - session request, honoured only when idle
//   abort     - terminate the current session and return to idle
//   core_load - one-cycle key/IV load command to the core
//   core_en   - core advances one step on each edge where high
//   core_ks   - keystream bit from the core, sampled while generating
//   ks_byte   - assembled keystream byte (holds last value while idle)
//   ks_valid  - ks_byte valid, held until accepted
//   ks_ready  - consumer accepts ks_byte on an edge with ks_valid high
//   busy      - high whenever a session is in progress
//   done      - one-cycle pulse after the last byte of a session is accepted
module trivium_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 1152,
  parameter int unsigned MAX_BYTES     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       core_load,
  output logic       core_en,
  input  logic       core_ks,
  output logic [7:0] ks_byte,
  output logic       ks_valid,
  input  logic       ks_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned WarmW = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
  localparam logic [15:0] MaxBytes = 16'(MAX_BYTES);

  typedef enum logic [2:0] {StIdle, StLoad, StWarm, StGen, StHold} state_e;

  state_e           state_q;
  logic [WarmW-1:0] warm_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [15:0]      byte_cnt_q;
  logic [7:0]       shreg_q;
  logic [7:0]       ks_byte_q;
  logic             core_load_q, core_en_q, ks_valid_q, busy_q, done_q;

  assign core_load = core_load_q;
  assign core_en   = core_en_q;
  assign ks_byte   = ks_byte_q;
  assign ks_valid  = ks_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Outputs are registered alongside the state so each reflects the state it is paired with.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shreg_q     <= '0;
      ks_byte_q   <= '0;
      core_load_q <= 1'b0;
      core_en_q   <= 1'b0;
      ks_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      core_load_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort && state_q != StIdle) begin
        // Abort wins over any handshake or transition; a partial byte is simply dropped.
        state_q    <= StIdle;
        core_en_q  <= 1'b0;
        ks_valid_q <= 1'b0;
        busy_q     <= 1'b0;
        bit_cnt_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              state_q     <= StLoad;
              core_load_q <= 1'b1;
              busy_q      <= 1'b1;
              warm_cnt_q  <= '0;
              byte_cnt_q  <= '0;
              bit_cnt_q   <= '0;
            end
          end
          StLoad: begin
            state_q   <= StWarm;
            core_en_q <= 1'b1;
          end
          StWarm: begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
            // core_en stays high: the first GEN step follows the last warm step directly.
            if (warm_cnt_q == WarmLast) begin
              state_q   <= StGen;
              bit_cnt_q <= '0;
            end
          end
          StGen: begin
            // Shift right so the first sampled bit ends up in bit 0.
            shreg_q   <= {core_ks, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              ks_byte_q  <= {core_ks, shreg_q[7:1]};
              ks_valid_q <= 1'b1;
              core_en_q  <= 1'b0;
              state_q    <= StHold;
            end
          end
          StHold: begin
            if (ks_ready) begin
              ks_valid_q <= 1'b0;
              byte_cnt_q <= byte_cnt_q + 16'd1;
              if (byte_cnt_q + 16'd1 == MaxBytes) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q   <= StGen;
                core_en_q <= 1'b1;
                bit_cnt_q <= '0;
              end
            end
          end
          default: begin
            state_q   <= StIdle;
            core_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
